a_row_loader: RTL and testbench
===============================

A_ROW_LOADER -- requirements
Module: a_row_loader

Interface
REQ-001 SHALL have parameter BITS_AB, default 8, meaning signed element width.
REQ-002 SHALL have parameter DIM, default 8, meaning array dimension (elements per row, rows per matrix).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  begins one matrix load when idle.
REQ-007 SHALL have port in_valid  input  1  upstream element valid.
REQ-008 SHALL have port in_data  input  BITS_AB signed  element, row-major order, column 0 first.
REQ-009 SHALL have port in_ready  output  1  element accepted on in_valid&&in_ready.
REQ-010 SHALL have port Ain  output  DIM x BITS_AB signed  assembled row to memA.
REQ-011 SHALL have port Arow  output  $clog2(DIM)  row index of current write.
REQ-012 SHALL have port WrEn  output  1  one-cycle row write strobe to memA.
REQ-013 SHALL have port en  output  1  memA shift enable during drain.
REQ-014 SHALL have port busy  output  1  high whenever state != IDLE.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, DRAIN, DONE.
REQ-017 IDLE: in_ready=0, WrEn=0, en=0; start=1 -> LOAD, with column counter col=0 and row counter row=0.
REQ-018 LOAD: in_ready=1; each accepted element is written to row-buffer slot col, then col increments.
REQ-019 in_valid=0 in LOAD SHALL hold col, row and the buffer unchanged; bubbles are legal anywhere.
REQ-020 On the edge accepting column DIM-1, the block SHALL register Ain (buffer plus this element), Arow=row and WrEn=1 for exactly the next cycle, then set col=0.
REQ-021 Ain and Arow SHALL hold their values until the next write; back-to-back rows SHALL sustain one element per cycle with no stall.
REQ-022 When row DIM-1 completes, the same edge SHALL move the FSM to DRAIN; otherwise row increments.
REQ-023 DRAIN SHALL last exactly 3*DIM-1 cycles, counted by drain counter dcnt=0..3*DIM-2.
REQ-024 In DRAIN, cycle dcnt=0 is the final WrEn cycle with en=0; en=1 for dcnt=1..3*DIM-2, i.e. 3*DIM-2 cycles.
REQ-025 In DRAIN, in_ready=0; in_valid SHALL be ignored.
REQ-026 After dcnt=3*DIM-2, the FSM SHALL enter DONE; DONE asserts done=1 for one cycle, then returns to IDLE.
REQ-027 start outside IDLE SHALL be ignored; start held high in IDLE at the DONE->IDLE return SHALL begin a new load on the following cycle.
REQ-028 WrEn and en SHALL never be high in the same cycle.
REQ-029 Data is passed through unmodified (no arithmetic, no sign extension); the Arow width equals the counter width.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE and set col, row, dcnt, Ain, Arow, WrEn, en, done, busy and in_ready to 0, from any state.
REQ-031 A reset mid-LOAD or mid-DRAIN SHALL discard the partial matrix and generate no done pulse.
REQ-032 A start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-033 Package a_ld_pkg SHALL hold the FSM state typedef and the DRAIN_CYC = 3*DIM-1 constant function.
REQ-034 No sub-module is required; the row buffer, counters and FSM SHALL live in one module, and all outputs SHALL be registered.

Verification (DIM=8, BITS_AB=8)
REQ-035 Continuous stream: start, then 64 beats of value k-32 -> 8 WrEn pulses, Arow 0..7 on consecutive 8-cycle boundaries, Ain row r = {8r-32 .. 8r-25}.
REQ-036 Random in_valid gaps (50%) -> same 8 rows and values as REQ-035, with WrEn only after each 8th accepted beat.
REQ-037 Drain timing: after the final WrEn -> en high for exactly 22 consecutive cycles, then done high for 1 cycle, then busy=0.
REQ-038 Reset at beat 20 -> all outputs 0 next cycle; a new start reloads from Arow=0 and the first Ain equals the new data.
REQ-039 start pulsed during LOAD and DRAIN -> no effect on counters, and exactly one done per matrix.
REQ-040 Extremes: elements -128 and 127 -> values appear bit-exact on Ain.

Source files
------------

// File: rtl/a_ld_pkg.sv
// Shared types and constants for the A-matrix row loader.
package a_ld_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } ld_state_t;

  // Number of DRAIN cycles: the final WrEn cycle plus the memA shift-out window.
  function automatic int drain_cyc(input int dim);
    return 3 * dim - 1;
  endfunction

endpackage

// File: rtl/a_row_loader.sv
// Collects a row-major element stream into DIM-wide rows, writes each row to memA,
// then drives the memA shift enable for the drain window and pulses done.
module a_row_loader
  import a_ld_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic signed [BITS_AB-1:0]           in_data,
  output logic                                in_ready,
  output logic signed [DIM-1:0][BITS_AB-1:0]  Ain,
  output logic [$clog2(DIM)-1:0]              Arow,
  output logic                                WrEn,
  output logic                                en,
  output logic                                busy,
  output logic                                done
);

  localparam int RW = $clog2(DIM);
  localparam int DC = drain_cyc(DIM);
  localparam int DW = $clog2(DC);

  ld_state_t state_reg, state_next;
  logic [RW-1:0] col_reg, col_next;
  logic [RW-1:0] row_reg, row_next;
  logic [DW-1:0] dcnt_reg, dcnt_next;
  logic signed [DIM-1:0][BITS_AB-1:0] ain_reg, ain_next;
  logic [RW-1:0] arow_reg, arow_next;
  logic wren_reg, wren_next;
  logic en_reg, en_next;
  logic done_reg, done_next;
  logic busy_reg, in_ready_reg;
  logic accept;

  // Slot DIM-1 is never stored: it is taken straight from in_data on the closing beat.
  logic signed [BITS_AB-1:0] row_buf_reg [DIM-1];
  logic signed [DIM-1:0][BITS_AB-1:0] row_full;

  assign accept = in_valid && (state_reg == ST_LOAD);

  for (genvar gi = 0; gi < DIM; gi++) begin : g_slot
    if (gi < DIM - 1) begin : g_buf
      always_ff @(posedge clk) begin
        if (rst) begin
          row_buf_reg[gi] <= '0;
        end else if (accept && (col_reg == RW'(gi))) begin
          row_buf_reg[gi] <= in_data;
        end
      end
      assign row_full[gi] = row_buf_reg[gi];
    end else begin : g_tail
      assign row_full[gi] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      col_reg      <= '0;
      row_reg      <= '0;
      dcnt_reg     <= '0;
      ain_reg      <= '0;
      arow_reg     <= '0;
      wren_reg     <= 1'b0;
      en_reg       <= 1'b0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      col_reg      <= col_next;
      row_reg      <= row_next;
      dcnt_reg     <= dcnt_next;
      ain_reg      <= ain_next;
      arow_reg     <= arow_next;
      wren_reg     <= wren_next;
      en_reg       <= en_next;
      done_reg     <= done_next;
      busy_reg     <= (state_next != ST_IDLE);
      in_ready_reg <= (state_next == ST_LOAD);
    end
  end

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    dcnt_next  = dcnt_reg;
    ain_next   = ain_reg;
    arow_next  = arow_reg;
    wren_next  = 1'b0;
    en_next    = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LOAD;
          col_next   = '0;
          row_next   = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (col_reg == RW'(DIM - 1)) begin
            ain_next  = row_full;
            arow_next = row_reg;
            wren_next = 1'b1;
            col_next  = '0;
            if (row_reg == RW'(DIM - 1)) begin
              state_next = ST_DRAIN;
              dcnt_next  = '0;
            end else begin
              row_next = row_reg + RW'(1);
            end
          end else begin
            col_next = col_reg + RW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // en is registered, so it is requested one cycle ahead of the dcnt it belongs to.
        if (dcnt_reg == DW'(DC - 1)) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else begin
          dcnt_next = dcnt_reg + DW'(1);
          en_next   = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign Ain      = ain_reg;
  assign Arow     = arow_reg;
  assign WrEn     = wren_reg;
  assign en       = en_reg;
  assign done     = done_reg;
  assign busy     = busy_reg;
  assign in_ready = in_ready_reg;

endmodule

// File: tb/tb_a_row_loader.sv
// Directed bench for a_row_loader: table of whole-matrix loads plus reset/restart sequences.
module tb_a_row_loader;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic signed [BITS_AB-1:0] in_data;
  logic in_ready, WrEn, en, busy, done;
  logic signed [DIM-1:0][BITS_AB-1:0] Ain;
  logic [2:0] Arow;

  always #5 clk = ~clk;

  a_row_loader #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .Ain(Ain), .Arow(Arow), .WrEn(WrEn), .en(en),
    .busy(busy), .done(done)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int         base;
    int         gap_pct;
    bit         noise;
    logic [7:0] r0c0;
    logic [7:0] r7c7;
  } vec_t;

  vec_t vecs[5];

  // One whole matrix: element k = base + k (8-bit wrap). Checks every row write and the drain.
  task automatic run_matrix(input vec_t v, input bit hold_start);
    int beat = 0, wr = 0, cyc = 0, last_wr = -100;
    int en_cnt = 0, en_first = -1, en_last = -1, done_cyc = -1, overlap = 0;
    bit fin = 1'b0;
    logic [63:0] row_exp;
    @(negedge clk); start = 1'b1; in_valid = 1'b0;
    @(negedge clk); start = 1'b0;
    while (!fin) begin
      if (WrEn) begin
        for (int c = 0; c < DIM; c++) row_exp[c*8 +: 8] = 8'(v.base + wr*DIM + c);
        check("ain_row", Ain, row_exp);
        check("arow", Arow, wr);
        check("beats_at_wren", beat, (wr + 1) * DIM);
        if (wr == 0) check("r0c0", {56'd0, Ain[0]}, v.r0c0);
        if (wr == DIM - 1) check("r7c7", {56'd0, Ain[DIM-1]}, v.r7c7);
        if (v.gap_pct == 0 && wr > 0) check("row_spacing", cyc - last_wr, DIM);
        last_wr = cyc;
        wr++;
      end
      if (WrEn && en) overlap++;
      if (en) begin
        if (en_first < 0) en_first = cyc;
        en_last = cyc;
        en_cnt++;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check("done_width", done, 0);
        check("busy_after", busy, 0);
        if (!hold_start) fin = 1'b1;
      end
      if (hold_start && done_cyc >= 0 && cyc == done_cyc + 2) begin
        check("restart_busy", busy, 1);
        check("restart_ready", in_ready, 1);
        fin = 1'b1;
      end
      // drive inputs for the next edge
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (in_ready && beat < DIM*DIM && $urandom_range(99) >= v.gap_pct) begin
        in_valid = 1'b1;
        in_data  = 8'(v.base + beat);
        beat++;
      end else if (!in_ready) begin
        in_valid = 1'($urandom_range(1));
      end
      start = 1'b0;
      if (v.noise) start = busy && !done && ($urandom_range(3) == 0);
      if (hold_start && done_cyc >= 0) start = 1'b1;
      cyc++;
      if (cyc > 3000) begin
        tests++;
        fails++;
        $display("FAIL timeout: got cycle %0d expected done within 3000", cyc);
        fin = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("wren_count", wr, DIM);
    check("wren_en_overlap", overlap, 0);
    check("en_count", en_cnt, 3*DIM - 2);
    check("en_first", en_first, last_wr + 1);
    check("en_last", en_last, last_wr + 3*DIM - 2);
    check("done_at", done_cyc, last_wr + 3*DIM - 1);
    $display("[TB] matrix base=%0d gap=%0d rows=%0d en=%0d done_at=%0d", v.base, v.gap_pct, wr, en_cnt, done_cyc);
  endtask

  task automatic quiet_check(input int n);
    int dcount = 0, bcount = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) dcount++;
      if (busy) bcount++;
    end
    check("quiet_done", dcount, 0);
    check("quiet_busy", bcount, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    vecs[0] = '{-32, 0,  1'b0, 8'hE0, 8'h1F};
    vecs[1] = '{-32, 50, 1'b0, 8'hE0, 8'h1F};
    vecs[2] = '{-128, 0, 1'b1, 8'h80, 8'hBF};
    vecs[3] = '{100, 30, 1'b1, 8'h64, 8'hA3};
    vecs[4] = '{64,  0,  1'b0, 8'h40, 8'h7F};

    repeat (3) @(negedge clk);
    check("reset_outputs", {Ain, 3'(Arow)}, 67'd0);
    check("reset_flags", {in_ready, WrEn, en, busy, done}, 5'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_matrix(vecs[i], 1'b0);
      quiet_check(10);
    end

    // reset at beat 20, with start asserted alongside reset
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_data = 8'(k + 1);
      @(negedge clk);
    end
    check("pre_rst_ain_nonzero", (Ain != '0), 1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("midload_rst_data", {Ain, 3'(Arow)}, 67'd0);
    check("midload_rst_flags", {in_ready, WrEn, en, busy, done}, 5'd0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("start_with_rst_ignored", busy, 0);
    $display("[TB] reset mid-load applied at beat 20");
    run_matrix('{40, 0, 1'b0, 8'h28, 8'h67}, 1'b0);

    // reset mid-drain: no done pulse may follow
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < DIM*DIM; k++) begin
      in_valid = 1'b1; in_data = 8'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("drain_en_before_rst", en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("middrain_rst_flags", {in_ready, WrEn, en, busy, done}, 5'd0);
    quiet_check(40);
    $display("[TB] reset mid-drain applied");

    // start held through DONE -> IDLE begins a new load
    run_matrix(vecs[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("final_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
